// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: FSM states, register map, bit positions.
// No logic lives here; imported by the timer top.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int STATUS_EXPIRED   = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Divides i_clk into one-cycle ticks every PRESCALE enabled cycles; tick is combinational from the counter.
// i_clear restarts the count at 0 and suppresses the tick; no backpressure.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && !i_clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Bus-mapped interval timer: CTRL/PERIOD/COUNT/STATUS registers, prescaled countdown FSM, sticky expiry irq.
// Reads return one cycle after i_rd; writes take effect at the sampling edge; no backpressure.
module mmio_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int WIDTH    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sel,
  input  logic [1:0]       i_addr,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic [WIDTH-1:0] i_wrdata,
  output logic [WIDTH-1:0] o_rddata,
  output logic             o_irq
);

  timer_state_t     state_q, state_d;
  logic             en_q, en_d;
  logic             auto_reload_q, auto_reload_d;
  logic             irq_en_q, irq_en_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic [WIDTH-1:0] rddata_q, rddata_d;

  logic sel_wr, sel_rd;
  logic ctrl_wr, period_wr, status_wr;
  logic start, stop, presc_en, tick;

  assign sel_wr    = i_sel && i_wr;
  assign sel_rd    = i_sel && i_rd;
  assign ctrl_wr   = sel_wr && (i_addr == REG_CTRL);
  assign period_wr = sel_wr && (i_addr == REG_PERIOD);
  assign status_wr = sel_wr && (i_addr == REG_STATUS);

  // An en=1 write only (re)starts from IDLE/DONE; while running it just updates the mode bits.
  assign start    = ctrl_wr && i_wrdata[CTRL_EN] && (state_q != RUN);
  assign stop     = ctrl_wr && !i_wrdata[CTRL_EN] && (state_q == RUN);
  assign presc_en = (state_q == RUN) && !stop;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (presc_en),
    .i_clear(start),
    .o_tick (tick)
  );

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    auto_reload_d = auto_reload_q;
    irq_en_d      = irq_en_q;
    period_d      = period_q;
    count_d       = count_q;
    expired_d     = expired_q;
    rddata_d      = rddata_q;

    if (period_wr) period_d = i_wrdata;
    if (status_wr && i_wrdata[STATUS_EXPIRED]) expired_d = 1'b0;
    if (ctrl_wr) begin
      en_d          = i_wrdata[CTRL_EN];
      auto_reload_d = i_wrdata[CTRL_AUTO_RELOAD];
      irq_en_d      = i_wrdata[CTRL_IRQ_EN];
    end

    // Expiry is evaluated after the STATUS clear so a same-cycle expiry keeps the flag set.
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          count_d = period_q;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else begin
            expired_d = 1'b1;
            if (auto_reload_q) begin
              count_d = period_q;
            end else begin
              en_d    = 1'b0;
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (sel_rd) begin
      case (i_addr)
        REG_CTRL:   rddata_d = WIDTH'({irq_en_q, auto_reload_q, en_q});
        REG_PERIOD: rddata_d = period_q;
        REG_COUNT:  rddata_d = count_q;
        REG_STATUS: rddata_d = WIDTH'(expired_q);
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      period_q      <= '0;
      count_q       <= '0;
      expired_q     <= 1'b0;
      rddata_q      <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      auto_reload_q <= auto_reload_d;
      irq_en_q      <= irq_en_d;
      period_q      <= period_d;
      count_q       <= count_d;
      expired_q     <= expired_d;
      rddata_q      <= rddata_d;
    end
  end

  assign o_rddata = rddata_q;
  assign o_irq    = expired_q && irq_en_q;

endmodule
